// File: rtl/countdown_timer_pkg.sv
// Shared constants for the countdown timer slice.
// Default counter width plus the idle and wrap target values.
package countdown_timer_pkg;

  localparam int COUNT_WIDTH = 6;

  localparam logic [COUNT_WIDTH-1:0] ZERO_COUNT     = '0;
  localparam logic [COUNT_WIDTH-1:0] ALL_ONES_COUNT = '1;

endpackage

// File: rtl/count_decrementer.sv
// Combinational subtract-one for the countdown register.
// is_one flags the edge that will expire the count; is_zero flags idle.
module count_decrementer #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] dec_val,
  output logic             is_one,
  output logic             is_zero
);

  assign dec_val = count - WIDTH'(1);
  assign is_one  = (count == WIDTH'(1));
  assign is_zero = (count == '0);

endmodule

// File: rtl/dffe_ref.sv
// Single-bit enabled flop with asynchronous active-high clear.
// This is the shared register primitive used across the datapath.
module dffe_ref (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= 1'b0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down counter with busy/zero status and a one-cycle done pulse.
// Load beats decrement; done fires only when a decrement takes 1 to 0.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH,
  parameter bit WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] cur_val,
  output logic             busy,
  output logic             zero,
  output logic             done
);

  localparam logic [WIDTH-1:0] ZERO_VAL = WIDTH'(ZERO_COUNT);
  localparam logic [WIDTH-1:0] WRAP_VAL =
    (WIDTH == COUNT_WIDTH) ? WIDTH'(ALL_ONES_COUNT) : {WIDTH{1'b1}};

  logic [WIDTH-1:0] dec_val;
  logic [WIDTH-1:0] next_val;
  logic             is_one;
  logic             is_zero;
  logic             next_done;
  logic             count_en;

  count_decrementer #(.WIDTH(WIDTH)) u_dec (
    .count   (cur_val),
    .dec_val (dec_val),
    .is_one  (is_one),
    .is_zero (is_zero)
  );

  always_comb begin
    next_val  = cur_val;
    next_done = 1'b0;
    if (load) begin
      next_val = load_val;
    end else if (en) begin
      if (!is_zero) begin
        next_val  = dec_val;
        next_done = is_one;
      end else begin
        next_val = WRAP ? WRAP_VAL : ZERO_VAL;
      end
    end
  end

  // Count bits only move on load or enable; the done flop samples every edge
  // so the pulse always self-clears.
  assign count_en = load | en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_count_bit
    dffe_ref u_bit (
      .clk   (clk),
      .reset (reset),
      .en    (count_en),
      .d     (next_val[i]),
      .q     (cur_val[i])
    );
  end

  dffe_ref u_done (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (next_done),
    .q     (done)
  );

  assign zero = is_zero;
  assign busy = ~is_zero;

endmodule
